// File: rtl/gf283_reduce_seq.sv
// ============================================================================
// gf283_reduce_seq
// ----------------------------------------------------------------------------
// Iterative modular reducer for GF(2^283). Takes the 565-bit carry-less
// product c[564:0] from the upstream multiplier and reduces it modulo
// f(x) = x^283 + x^12 + x^7 + x^5 + 1, folding up to FOLD_W high bits per
// clock. The operand is registered on the accept edge, so the multiplier
// output only has to be stable for that one edge.
//
// Parameters:
//   FOLD_W   product bits folded per cycle, legal range 1..271.
//            Fold count N = ceil(282/FOLD_W) (N = 6 for the default 47).
//
// Ports:
//   clk        in   1    single clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    prod is valid
//   in_ready   out  1    block accepts prod this cycle
//   prod       in   565  carry-less product c[564:0]
//   out_valid  out  1    r holds the reduced result
//   out_ready  in   1    consumer accepts r
//   r          out  283  c mod f(x)
//   busy       out  1    high while folding
//
// Optional feature (compile-time macro GF283_ZERO_SKIP_EN):
//   When defined, an operand whose high part prod[564:283] is zero bypasses
//   the fold loop: r = prod[282:0] is presented one edge after accept and
//   busy stays low. When undefined, every operand takes the full N folds,
//   so latency is constant regardless of data.
// ============================================================================
module gf283_reduce_seq #(
    parameter int FOLD_W = 47
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [564:0] prod,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [282:0] r,
    output logic         busy
);

    // Number of fold steps needed to clear bits 564..283.
    localparam int N     = (282 + FOLD_W - 1) / FOLD_W;
    localparam int CNT_W = 9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FOLD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_PASS = 2'd3;

    // ------------------------------------------------------------------------
    // Lowest bit of the chunk folded at step k: max(283, 565 - (k+1)*FOLD_W).
    // ------------------------------------------------------------------------
    function automatic logic [9:0] fold_lo(input logic [CNT_W-1:0] k);
        int t;
        t = 565 - (int'(k) + 1) * FOLD_W;
        if (t < 283) begin
            t = 283;
        end else begin
            t = t;
        end
        return t[9:0];
    endfunction

    // ------------------------------------------------------------------------
    // One fold step. Every bit above the current chunk top is already zero
    // (earlier chunks were cleared and their images land at most 271 bits
    // lower, i.e. at or below the next chunk top), so the chunk is simply
    // "all bits at or above lo". A chunk bit at position p is replaced by
    // bits p-283, p-278, p-276, p-271 (x^283 == x^12 + x^7 + x^5 + 1), which
    // turns the per-step reduction into constant shifts plus one mask.
    // ------------------------------------------------------------------------
    function automatic logic [564:0] fold_step(input logic [564:0] w,
                                               input logic [CNT_W-1:0] k);
        logic [564:0] mask;
        logic [564:0] chunk;
        mask  = {565{1'b1}} << fold_lo(k);
        chunk = w & mask;
        return (w ^ chunk)
             ^ (chunk >> 10'd283)
             ^ (chunk >> 10'd278)
             ^ (chunk >> 10'd276)
             ^ (chunk >> 10'd271);
    endfunction

    logic [1:0]       state_q,     state_d;
    logic [564:0]     w_q,         w_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [282:0]     r_q,         r_d;
    logic             out_valid_q, out_valid_d;
    logic             ready_en_q;

    logic             in_ready_s;
    logic             accept_s;
    logic [564:0]     w_fold_s;
    logic             last_fold_s;
    logic [1:0]       accept_state_s;

    // Handshake decode; ready_en_q keeps in_ready low while in reset.
    always_comb begin
        in_ready_s  = ready_en_q &&
                      ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
        accept_s    = in_valid && in_ready_s;
        w_fold_s    = fold_step(w_q, cnt_q);
        last_fold_s = (cnt_q == CNT_W'(N - 1));
    end

    // State entered on accept: pass-through for a zero high part if enabled.
    always_comb begin
`ifdef GF283_ZERO_SKIP_EN
        if (prod[564:283] == 282'd0) begin
            accept_state_s = ST_PASS;
        end else begin
            accept_state_s = ST_FOLD;
        end
`else
        accept_state_s = ST_FOLD;
`endif
    end

    // Next-state and datapath logic for the fold sequencer.
    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    w_d     = prod;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = accept_state_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FOLD: begin
                w_d = w_fold_s;
                if (last_fold_s) begin
                    // High half is zero after the last fold; publish now.
                    state_d     = ST_DONE;
                    r_d         = w_fold_s[282:0];
                    out_valid_d = 1'b1;
                    cnt_d       = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_PASS: begin
                // Operand already below degree 283: register it out unchanged.
                state_d     = ST_DONE;
                r_d         = w_q[282:0];
                out_valid_d = 1'b1;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (accept_s) begin
                        w_d     = prod;
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = accept_state_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    // Backpressure: hold r and out_valid.
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer state, working register, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            w_q         <= 565'd0;
            cnt_q       <= {CNT_W{1'b0}};
            r_q         <= 283'd0;
            out_valid_q <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            out_valid_q <= out_valid_d;
            ready_en_q  <= 1'b1;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign r         = r_q;
    assign busy      = (state_q == ST_FOLD);

endmodule

// File: doc/gf283_reduce_seq.md
Name: gf283_reduce_seq

Overview:
- Iterative modular reducer for GF(2^283).
- Sits directly downstream of the 283-bit Karatsuba multiplier and consumes its 565-bit carry-less product.
- Reduces the product modulo f(x) = x^283 + x^12 + x^7 + x^5 + 1, folding FOLD_W high bits per clock.
- Registers its operand, so the combinational multiplier output only has to be stable on the accept edge.

Parameters:
- FOLD_W, 47, number of product bits folded per cycle. Legal range 1..271. Fold count N = ceil(282/FOLD_W), so the default gives N = 6.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  prod is valid.
- in_ready  output  1  block can accept prod this cycle.
- prod  input  565  carry-less product c[564:0] from the multiplier.
- out_valid  output  1  r holds the reduced result.
- out_ready  input  1  consumer accepts r.
- r  output  283  c mod f(x), bits [282:0].
- busy  output  1  high in FOLD state.

Behaviour:
- Reset is asynchronous and active-low; the single clock is clk. While rst_n=0: state=IDLE; working register W, fold counter and r are cleared; out_valid=0; busy=0; in_ready=0 on the reset cycle.
- Asserting rst_n low mid-fold aborts the operation, discards W, and produces no output.
- States and transitions:
  - IDLE -> FOLD on accept.
  - FOLD -> FOLD while cnt < N-1.
  - FOLD -> DONE on the edge completing fold N-1.
  - DONE -> IDLE when out_ready=1 and no new accept.
  - DONE -> FOLD when out_ready=1 and a new accept occurs in the same cycle.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept = in_valid && in_ready. On accept: W <= prod, cnt <= 0.
- Fold step k (k = 0..N-1):
  - top = 564 - k*FOLD_W; lo = max(283, top-FOLD_W+1).
  - Chunk C = W[top:lo], zeroed in W.
  - C is XORed into W at offsets (lo-283) + {0, 5, 7, 12}.
  - Targets never overlap the chunk (FOLD_W <= 271 guarantees this). Bits landing at or above 283 are removed by later steps.
  - The final chunk may be narrower than FOLD_W.
- After step N-1, W[564:283] is zero. r <= W[282:0] on that same edge; out_valid <= 1.
- Latency: out_valid rises exactly N rising edges after the accept edge (6 at default).
- Sustained throughput is one result per N+1 cycles when out_ready is held high.
- r and out_valid are held stable while out_valid=1 and out_ready=0, for arbitrarily long backpressure.
- prod is sampled only on the accept edge; later changes are ignored.
- in_valid while busy is ignored; in_ready=0 during FOLD.
- All arithmetic is GF(2): XOR only, no carries.

Optional Feature:
- Macro: GF283_ZERO_SKIP_EN.
- Defined: on accept, if prod[564:283]==0, the block goes straight to DONE with r <= prod[282:0]. out_valid rises 1 edge after accept and busy stays 0.
- Undefined: every operand takes the full N folds, giving constant latency regardless of data.

Test Plan:
- prod = 1<<283, FOLD_W=47 -> out_valid exactly 6 edges after accept; r = 0x10A1 (bits 12, 7, 5, 0).
- prod = 1<<564 -> r has only bits 281, 22, 12, 10, 8, 5, 3 set.
- prod = 0x1234 (high part zero) -> r = 0x1234. Latency 6 without GF283_ZERO_SKIP_EN, 1 with it.
- Random 565-bit prods, FOLD_W in {1, 47, 141, 271} -> r matches software polynomial-mod reference. Latency equals ceil(282/FOLD_W).
- Hold out_ready=0 for 20 cycles after out_valid while toggling prod and in_valid -> r and out_valid stable, in_ready=0. Then out_ready=1 together with in_valid=1 -> next operand accepted in that same cycle.
- Drop rst_n mid-FOLD at step 3, release, then present prod = 1<<283 -> no stale out_valid; fresh result r = 0x10A1 with normal latency.
